// File: rtl/mips_cpu_state_sequencer.sv
// mips_cpu_state_sequencer: multicycle FETCH/DECODE/EXEC1/EXEC2 sequencer with memory stall and jump-to-0 halt.
// Optional performance counters are built when MIPS_CPU_PERF_COUNTERS_EN is defined.
module mips_cpu_state_sequencer (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [5:0]  opcode,
   input  logic        mem_req,
   input  logic        mem_waitrequest,
   input  logic        pcwrite,
   input  logic [31:0] pc_next,
   output logic [2:0]  state,
   output logic        active,
   output logic        instr_done,
   output logic [31:0] cycle_count,
   output logic [31:0] instr_count
);
   typedef enum logic [2:0] {
      S_HALTED = 3'd0,
      S_FETCH  = 3'd1,
      S_DECODE = 3'd2,
      S_EXEC1  = 3'd3,
      S_EXEC2  = 3'd4
   } state_t;
   state_t r_state, w_next;
   logic   r_active, r_halt_pending;
   logic   w_stall, w_set, w_final, w_halt;
   always_comb begin
      w_stall    = mem_req & mem_waitrequest;
      w_set      = pcwrite & (pc_next == 32'h0) &
                   (r_state == S_DECODE || r_state == S_EXEC1 || r_state == S_EXEC2);
      // j/beq/bne resolve in EXEC1; everything else needs EXEC2
      w_final    = (r_state == S_EXEC2) ||
                   (r_state == S_EXEC1 && (opcode == 6'h02 || opcode == 6'h04 || opcode == 6'h05));
      w_halt     = r_halt_pending | w_set;
      instr_done = w_final & ~w_stall;
      w_next     = S_FETCH;
      case (r_state)
         S_HALTED:         w_next = S_HALTED;
         S_FETCH:          w_next = w_stall ? S_FETCH : S_DECODE;
         S_DECODE:         w_next = w_stall ? S_DECODE : S_EXEC1;
         S_EXEC1, S_EXEC2: w_next = w_stall ? r_state : instr_done ? (w_halt ? S_HALTED : S_FETCH) : S_EXEC2;
         default:          w_next = S_FETCH;
      endcase
   end
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_state        <= S_FETCH;
         r_active       <= 1'b1;
         r_halt_pending <= 1'b0;
      end else begin
         r_state        <= w_next;
         r_active       <= (w_next != S_HALTED);
         r_halt_pending <= (w_next == S_FETCH) ? 1'b0 : (r_halt_pending | w_set);
      end
   end
   assign state  = r_state;
   assign active = r_active;
`ifdef MIPS_CPU_PERF_COUNTERS_EN
   logic [31:0] r_cycle_count, r_instr_count;
   // both freeze in HALTED since active and instr_done are then 0
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_cycle_count <= 32'h0;
         r_instr_count <= 32'h0;
      end else begin
         if (r_active)   r_cycle_count <= r_cycle_count + 32'h1;
         if (instr_done) r_instr_count <= r_instr_count + 32'h1;
      end
   end
   assign cycle_count = r_cycle_count;
   assign instr_count = r_instr_count;
`else
   assign cycle_count = 32'h0;
   assign instr_count = 32'h0;
`endif
endmodule

// File: tb/tb_mips_cpu_state_sequencer.sv
// tb_mips_cpu_state_sequencer: directed per-cycle vectors push expected outputs into a queue;
// a negedge monitor pops and compares state/active/instr_done and, where requested, the counters.
module tb_mips_cpu_state_sequencer;
   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic [5:0]  opcode = 6'h0;
   logic        mem_req = 1'b0;
   logic        mem_waitrequest = 1'b0;
   logic        pcwrite = 1'b0;
   logic [31:0] pc_next = 32'h0;
   logic [2:0]  state;
   logic        active;
   logic        instr_done;
   logic [31:0] cycle_count;
   logic [31:0] instr_count;
   localparam logic [5:0] OP_R = 6'h00, OP_J = 6'h02, OP_BEQ = 6'h04, OP_BNE = 6'h05, OP_LW = 6'h23;
`ifdef MIPS_CPU_PERF_COUNTERS_EN
   localparam logic [31:0] CYC_FINAL = 32'd12, INS_FINAL = 32'd3;
`else
   localparam logic [31:0] CYC_FINAL = 32'd0, INS_FINAL = 32'd0;
`endif
   typedef struct {
      logic [2:0]  st;
      logic        act;
      logic        done;
      logic        cc;
      logic [31:0] ecyc;
      logic [31:0] eins;
   } exp_t;
   exp_t q[$];
   exp_t m_e;
   int   n_chk = 0;
   int   n_pass = 0;
   int   n_seq = 0;
   mips_cpu_state_sequencer dut (
      .clk(clk), .reset_n(reset_n), .opcode(opcode), .mem_req(mem_req),
      .mem_waitrequest(mem_waitrequest), .pcwrite(pcwrite), .pc_next(pc_next),
      .state(state), .active(active), .instr_done(instr_done),
      .cycle_count(cycle_count), .instr_count(instr_count)
   );
   always #5 clk = ~clk;
   task automatic cyc_full(input logic rn, input logic [5:0] op, input logic mr, input logic mw,
                           input logic pw, input logic [31:0] pn, input logic [2:0] es, input logic ed,
                           input logic cc, input logic [31:0] ec, input logic [31:0] ei);
      @(posedge clk);
      #1;
      reset_n = rn;
      opcode = op;
      mem_req = mr;
      mem_waitrequest = mw;
      pcwrite = pw;
      pc_next = pn;
      q.push_back('{st: es, act: (es != 3'd0), done: ed, cc: cc, ecyc: ec, eins: ei});
   endtask
   task automatic cyc(input logic rn, input logic [5:0] op, input logic mr, input logic mw,
                      input logic pw, input logic [31:0] pn, input logic [2:0] es, input logic ed);
      cyc_full(rn, op, mr, mw, pw, pn, es, ed, 1'b0, 32'h0, 32'h0);
   endtask
   always @(negedge clk) begin
      if (q.size() != 0) begin
         m_e = q.pop_front();
         n_seq++;
         n_chk++;
         if ({state, active, instr_done} === {m_e.st, m_e.act, m_e.done}) n_pass++;
         else $display("FAIL seq%0d state/active/instr_done: got %0d/%0b/%0b want %0d/%0b/%0b",
                       n_seq, state, active, instr_done, m_e.st, m_e.act, m_e.done);
         if (m_e.cc) begin
            n_chk++;
            if (cycle_count === m_e.ecyc && instr_count === m_e.eins) n_pass++;
            else $display("FAIL seq%0d counters: got cyc=%0d ins=%0d want cyc=%0d ins=%0d",
                          n_seq, cycle_count, instr_count, m_e.ecyc, m_e.eins);
         end
      end
   end
   initial begin
      repeat (2) @(posedge clk);
      // R-type, no stalls; nonzero PC write in EXEC2 must not halt
      cyc_full(1, OP_R, 0, 0, 0, 32'h0, 1, 0, 1'b1, 32'h0, 32'h0);
      cyc(1, OP_R, 0, 0, 0, 32'h0, 2, 0);
      cyc(1, OP_R, 0, 0, 0, 32'h0, 3, 0);
      cyc(1, OP_R, 0, 0, 1, 32'h100, 4, 1);
      // beq then bne: final in EXEC1
      cyc(1, OP_BEQ, 0, 0, 0, 32'h0, 1, 0);
      cyc(1, OP_BEQ, 0, 0, 0, 32'h0, 2, 0);
      cyc(1, OP_BEQ, 0, 0, 0, 32'h0, 3, 1);
      cyc(1, OP_BNE, 0, 0, 0, 32'h0, 1, 0);
      cyc(1, OP_BNE, 0, 0, 0, 32'h0, 2, 0);
      cyc(1, OP_BNE, 0, 0, 0, 32'h0, 3, 1);
      // lw with 3 wait-state cycles in EXEC1
      cyc(1, OP_LW, 0, 0, 0, 32'h0, 1, 0);
      cyc(1, OP_LW, 0, 0, 0, 32'h0, 2, 0);
      repeat (3) cyc(1, OP_LW, 1, 1, 0, 32'h0, 3, 0);
      cyc(1, OP_LW, 1, 0, 0, 32'h0, 3, 0);
      cyc(1, OP_LW, 0, 0, 0, 32'h0, 4, 1);
      // fetch stall for 2 cycles; waitrequest without mem_req is ignored
      repeat (2) cyc(1, OP_R, 1, 1, 0, 32'h0, 1, 0);
      cyc(1, OP_R, 1, 0, 0, 32'h0, 1, 0);
      cyc(1, OP_R, 0, 1, 0, 32'h0, 2, 0);
      cyc(1, OP_R, 0, 1, 0, 32'h0, 3, 0);
      cyc(1, OP_R, 0, 1, 0, 32'h0, 4, 1);
      // pc_next=0 written in FETCH does not halt
      cyc(1, OP_J, 0, 0, 1, 32'h0, 1, 0);
      cyc(1, OP_J, 0, 0, 0, 32'h0, 2, 0);
      cyc(1, OP_J, 0, 0, 0, 32'h0, 3, 1);
      // jr to 0 in EXEC2 halts
      cyc(1, OP_R, 0, 0, 0, 32'h0, 1, 0);
      cyc(1, OP_R, 0, 0, 0, 32'h0, 2, 0);
      cyc(1, OP_R, 0, 0, 0, 32'h0, 3, 0);
      cyc(1, OP_R, 0, 0, 1, 32'h0, 4, 1);
      for (int i = 0; i < 100; i++)
         cyc(1, 6'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), $urandom, 0, 0);
      // halt_pending set in DECODE, honoured at the j's final EXEC1
      cyc(0, OP_J, 0, 0, 0, 32'h0, 0, 0);
      cyc(1, OP_J, 0, 0, 0, 32'h0, 1, 0);
      cyc(1, OP_J, 0, 0, 1, 32'h0, 2, 0);
      cyc(1, OP_J, 0, 0, 0, 32'h0, 3, 1);
      cyc(1, OP_J, 0, 0, 0, 32'h0, 0, 0);
      // reset during an EXEC1 stall aborts with no instr_done
      cyc(0, OP_LW, 0, 0, 0, 32'h0, 0, 0);
      cyc(1, OP_LW, 0, 0, 0, 32'h0, 1, 0);
      cyc(1, OP_LW, 0, 0, 0, 32'h0, 2, 0);
      cyc(1, OP_LW, 1, 1, 0, 32'h0, 3, 0);
      cyc(0, OP_LW, 1, 1, 0, 32'h0, 3, 0);
      cyc(1, OP_BEQ, 0, 0, 0, 32'h0, 1, 0);
      cyc(1, OP_BEQ, 0, 0, 0, 32'h0, 2, 0);
      cyc(1, OP_BEQ, 0, 0, 0, 32'h0, 3, 1);
      // pending halt survives a stall in the final EXEC2
      cyc(1, OP_R, 0, 0, 0, 32'h0, 1, 0);
      cyc(1, OP_R, 0, 0, 1, 32'h0, 2, 0);
      cyc(1, OP_R, 0, 0, 0, 32'h0, 3, 0);
      cyc(1, OP_R, 1, 1, 0, 32'h0, 4, 0);
      cyc(1, OP_R, 0, 0, 0, 32'h0, 4, 1);
      cyc(1, OP_R, 0, 0, 0, 32'h0, 0, 0);
      // counters: 3 R-type then halt, frozen afterwards
      cyc(0, OP_R, 0, 0, 0, 32'h0, 0, 0);
      for (int k = 0; k < 3; k++) begin
         cyc_full(1, OP_R, 0, 0, 0, 32'h0, 1, 0, (k == 0), 32'h0, 32'h0);
         cyc(1, OP_R, 0, 0, 0, 32'h0, 2, 0);
         cyc(1, OP_R, 0, 0, 0, 32'h0, 3, 0);
         cyc(1, OP_R, 0, 0, (k == 2), 32'h0, 4, 1);
      end
      repeat (3) cyc_full(1, OP_R, 1, 0, 1, 32'h0, 0, 0, 1'b1, CYC_FINAL, INS_FINAL);
      for (int i = 0; i < 10 && q.size() != 0; i++) @(posedge clk);
      if (q.size() != 0) begin
         n_chk++;
         $display("FAIL drain: got %0d pending entries want 0", q.size());
      end
      #1;
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
